// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a 4-entry byte FIFO over a valid/ready handshake.
// Bit timing comes from a fixed integer clock divisor; back-to-back frames have no idle gap.
module uart_tx_fifo #(
  parameter int CLK_DIV = 104,
  parameter int DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic [2:0] fifo_level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [7:0]      shift;
  logic [15:0]     cnt;
  logic [2:0]      bit_idx;
  logic            push, pop, bit_end;

  assign tx_ready = fifo_level < 3'(DEPTH);
  assign push     = tx_valid && tx_ready;
  assign bit_end  = (cnt == 16'd0);
  // Pop either from idle, or on the last stop-bit cycle so the next start bit follows immediately.
  assign pop      = (fifo_level != 3'd0) &&
                    ((state == IDLE) || ((state == STOP) && bit_end));

  always_ff @(posedge clk) begin
    if (push && rst_n) mem[tail] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      head       <= '0;
      tail       <= '0;
      fifo_level <= 3'd0;
      shift      <= 8'd0;
      cnt        <= 16'd0;
      bit_idx    <= 3'd0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 3'd1;
        2'b01:   fifo_level <= fifo_level - 3'd1;
        default: ;
      endcase

      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift <= mem[head];
            state <= START;
            tx    <= 1'b0;
            busy  <= 1'b1;
            cnt   <= RELOAD;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            tx      <= shift[0];
            bit_idx <= 3'd0;
            cnt     <= RELOAD;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= RELOAD;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              shift <= mem[head];
              state <= START;
              tx    <= 1'b0;
              cnt   <= RELOAD;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: one instance at CLK_DIV=4, one at the minimum divisor of 2.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d4 = 8'h00, d2 = 8'h00;
  logic       v4 = 1'b0, v2 = 1'b0;
  logic       rdy4, tx4, busy4, rdy2, tx2, busy2;
  logic [2:0] lvl4, lvl2;
  int         n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_DIV(4), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .tx_data(d4), .tx_valid(v4),
    .tx_ready(rdy4), .tx(tx4), .busy(busy4), .fifo_level(lvl4));

  uart_tx_fifo #(.CLK_DIV(2), .DEPTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(d2), .tx_valid(v2),
    .tx_ready(rdy2), .tx(tx2), .busy(busy2), .fifo_level(lvl2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Each frame bit held for 4 cycles; cycle i of the frame lands in bit i.
  function automatic logic [39:0] frame4(input logic [7:0] b);
    logic [9:0]  f;
    logic [39:0] r;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 40; i++) r[i] = f[i/4];
    return r;
  endfunction

  task automatic cap(input bit sel2, input int n, output logic [79:0] v, output int bc);
    v = '0;
    bc = 0;
    for (int i = 0; i < n; i++) begin
      v[i] = sel2 ? tx2 : tx4;
      bc += int'(sel2 ? busy2 : busy4);
      step();
    end
  endtask

  logic [79:0]  vv;
  logic [239:0] obs;
  int           bc, idx, e, bad;
  int           acc_e [6];
  logic         acc;

  initial begin
    // reset held 3 edges with a push presented
    v4 = 1'b1; d4 = 8'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_tx", tx4, 1);
      chk("rst_busy", busy4, 0);
      chk("rst_lvl", lvl4, 0);
      chk("rst_rdy", rdy4, 1);
    end
    rst_n = 1'b1; v4 = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx4 !== 1'b1 || busy4 !== 1'b0 || lvl4 !== 3'd0) bad++;
      step();
    end
    chk("rst_quiet", bad, 0);

    // single byte 0xA5
    v4 = 1'b1; d4 = 8'hA5;
    step();
    v4 = 1'b0;
    chk("sb_lvl1", lvl4, 1);
    chk("sb_tx_pre", tx4, 1);
    chk("sb_busy_pre", busy4, 0);
    step();
    chk("sb_tx_fall", tx4, 0);
    chk("sb_busy_rise", busy4, 1);
    chk("sb_lvl0", lvl4, 0);
    cap(1'b0, 40, vv, bc);
    chk("sb_frame", vv[39:0], 40'hFF0F00F0F0);
    chk("sb_busy_cnt", bc, 40);
    chk("sb_busy_end", busy4, 0);
    chk("sb_tx_end", tx4, 1);
    repeat (5) step();

    // back-to-back 0x00 then 0xFF
    v4 = 1'b1; d4 = 8'h00;
    step();
    d4 = 8'hFF;
    step();
    v4 = 1'b0;
    chk("b2b_tx_fall", tx4, 0);
    chk("b2b_lvl", lvl4, 1);
    cap(1'b0, 80, vv, bc);
    chk("b2b_f0", vv[39:0], frame4(8'h00));
    chk("b2b_f1", vv[79:40], frame4(8'hFF));
    chk("b2b_busy_cnt", bc, 80);
    chk("b2b_busy_end", busy4, 0);
    repeat (5) step();

    // FIFO full: 6 bytes offered continuously
    idx = 0; e = 0; obs = '0;
    for (int i = 0; i < 6; i++) acc_e[i] = -1;
    while (e < 242) begin
      if (e >= 2) obs[e-2] = tx4;
      if (e == 2)  begin chk("full_pop_tx", tx4, 0); chk("full_lvl_e2", lvl4, 1); end
      if (e == 5)  begin chk("full_lvl_e5", lvl4, 4); chk("full_rdy_e5", rdy4, 0); end
      if (e == 41) chk("full_rdy_e41", rdy4, 0);
      if (e == 42) chk("full_lvl_e42", lvl4, 3);
      if (e == 43) chk("full_lvl_e43", lvl4, 4);
      if (idx < 6) begin v4 = 1'b1; d4 = 8'(idx + 1); end
      else v4 = 1'b0;
      acc = v4 && rdy4;
      step();
      e++;
      if (acc) begin acc_e[idx] = e; idx++; end
    end
    v4 = 1'b0;
    chk("full_acc0", acc_e[0], 1);
    chk("full_acc1", acc_e[1], 2);
    chk("full_acc4", acc_e[4], 5);
    chk("full_acc5", acc_e[5], 43);
    for (int f = 0; f < 6; f++) chk($sformatf("full_frame%0d", f), obs[f*40 +: 40], frame4(8'(f + 1)));
    chk("full_busy_end", busy4, 0);
    chk("full_lvl_end", lvl4, 0);
    repeat (5) step();

    // reset during data bit 3 of the first of 3 queued frames
    v4 = 1'b1; d4 = 8'h11;
    step();
    d4 = 8'h22;
    step();
    d4 = 8'h33;
    step();
    v4 = 1'b0;
    chk("mid_lvl", lvl4, 2);
    repeat (16) step();
    chk("mid_bit3", tx4, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_tx", tx4, 1);
    chk("mid_busy", busy4, 0);
    chk("mid_lvl0", lvl4, 0);
    chk("mid_rdy", rdy4, 1);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx4 !== 1'b1 || busy4 !== 1'b0) bad++;
      step();
    end
    chk("mid_quiet", bad, 0);

    // minimum divisor, 0x80
    v2 = 1'b1; d2 = 8'h80;
    step();
    v2 = 1'b0;
    chk("min_lvl1", lvl2, 1);
    step();
    chk("min_busy", busy2, 1);
    cap(1'b1, 20, vv, bc);
    chk("min_frame", vv[19:0], 20'hF0000);
    chk("min_busy_cnt", bc, 20);
    chk("min_busy_end", busy2, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-serial UART transmitter for the KianV SoC peripheral bus, the transmit-side counterpart of the SoC UART receiver. It accepts bytes through a valid/ready handshake into a 4-entry FIFO and serialises each byte as an 8N1 frame (start bit, 8 data bits LSB first, stop bit) on a single output line. Bit timing is derived from the system clock by a fixed integer divisor. There is no flow control and no parity.

## Interface

- `CLK_DIV`, default 104: system clock cycles per UART bit; legal range 2..65535.
- `DEPTH`, default 4: FIFO entries, power of two, fixed at 4 for this block.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `tx_data`  in  8  byte to transmit.
- `tx_valid`  in  1  `tx_data` is valid this cycle.
- `tx_ready`  out  1  FIFO can accept a byte; equals `fifo_level < DEPTH`, combinational from the registered count.
- `tx`  out  1  serial line, registered; idles high.
- `busy`  out  1  registered; high while the FSM is not IDLE.
- `fifo_level`  out  3  registered count of queued bytes, 0..4. Excludes the byte currently in the shift register.

## Operation

- Push: a byte is written into the FIFO on any rising edge where `tx_valid && tx_ready`. The tail pointer wraps modulo 4.
- Pop: the head byte is taken when the FSM is in IDLE with `fifo_level != 0`, or at the last cycle of STOP with `fifo_level != 0`. Popping loads the 8-bit shift register and enters START.
- Push and pop on the same edge: `fifo_level` is unchanged and both pointers advance.
- When the FIFO is full, `tx_ready` is 0 even if a pop occurs on the same edge. The push is accepted on a following cycle.
- FSM states:
  - IDLE: `tx`=1, baud counter held.
  - START: `tx`=0 for `CLK_DIV` cycles, then DATA with bit index 0.
  - DATA: `tx`=shift[0] for `CLK_DIV` cycles per bit; shift right after each bit; after bit index 7, go to STOP.
  - STOP: `tx`=1 for `CLK_DIV` cycles. Then go to START if the FIFO is non-empty (pop), otherwise IDLE.
- Baud counter: 16 bits, loaded with `CLK_DIV-1` on every state or bit entry and decremented each cycle. The bit period ends when the counter reaches 0.
- Bit index: 3 bits, 0..7. No other wrap is permitted.
- Reset (`rst_n`=0 at an edge), from any state including mid-frame:
  - FSM goes to IDLE, `tx`=1, `busy`=0.
  - FIFO pointers and `fifo_level` go to 0; queued bytes are discarded.
  - Shift register is cleared.
  - A push presented during a reset edge is ignored.
- After the first reset edge, `tx_ready`=1.

## Timing

- Reset values of the outputs: `tx`=1, `busy`=0, `fifo_level`=0, `tx_ready`=1.
- Latency, starting with FIFO empty and FSM in IDLE:
  - Byte pushed at edge k: `fifo_level`=1 after k.
  - Pop at edge k+1: `tx` falls to 0, `busy` rises, `fifo_level` returns to 0.
  - The falling edge of `tx` is therefore 1 cycle after the push edge.
- Frame length: exactly 10×`CLK_DIV` cycles from the falling edge of `tx` to the end of the stop bit.
- Back-to-back: with the FIFO non-empty at the end of STOP, the next start bit begins on the immediately following cycle. There is no extra idle cycle, so the sustained rate is one byte per 10×`CLK_DIV` cycles.
- `busy` falls on the edge that returns the FSM to IDLE, i.e. 10×`CLK_DIV` cycles after it rose for the last frame.
- `tx` never glitches: it changes only on clock edges and only at bit boundaries.

## Test plan

- Reset:
  - Hold `rst_n`=0 for 3 cycles with `tx_valid`=1 and `tx_data`=0x55.
  - Required: `tx`=1, `busy`=0, `fifo_level`=0 throughout; `tx_ready`=1 after the first edge; nothing is transmitted after release.
- Single byte, `CLK_DIV`=4:
  - Push 0xA5.
  - Required: `tx` goes low 1 cycle after the push edge.
  - Required 4-cycle bit sequence: 0, 1,0,1,0,0,1,0,1, 1 (40 cycles in total).
  - Required: `busy` high for exactly 40 cycles.
- Back-to-back, `CLK_DIV`=4:
  - Push 0x00 then 0xFF on consecutive cycles.
  - Required: 80 cycles of continuous framing with no idle gap between the stop bit of 0x00 and the start bit of 0xFF.
- FIFO full, `CLK_DIV`=4:
  - Hold `tx_valid`=1 with bytes 0x01..0x06 starting at edge 1.
  - Required: 0x01 is popped at edge 2; `fifo_level` reaches 4 after edge 5; `tx_ready` drops to 0.
  - Required: 0x06 is held until the pop at the end of frame 0x01, then accepted.
  - Required: all 6 bytes appear on `tx` in order.
- Reset mid-frame:
  - Queue 3 bytes; assert `rst_n`=0 during data bit 3 of the first frame.
  - Required: `tx`=1 at the next edge, `fifo_level`=0, and no further frames after release.
- Minimum divisor, `CLK_DIV`=2:
  - Push 0x80.
  - Required: 20-cycle frame with `tx` low for cycles 0..15 and high for cycles 16..19 (data bit 7 and stop bit).
